// File: rtl/rc4_ksa_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : rc4_ksa_fsm_if
//  Purpose  : Bundle of start/key inputs, S RAM bus and status outputs
//             between the RC4 key-scheduling FSM and its environment.
//  Ports (named from the key-scheduler's point of view):
//    i_start       begin scheduling (sampled only while idle)
//    i_secret_key  key, byte 0 in the most significant byte
//    i_s_q         S RAM read data
//    o_address     S RAM address
//    o_data        S RAM write data
//    o_s_wren      S RAM write enable
//    o_busy        scheduler is not idle
//    o_finish      one-cycle pulse when S RAM is fully scheduled
//  Revision : 1.0  initial release
// ============================================================================
interface rc4_ksa_fsm_if #(
  parameter int KEY_LENGTH = 3
);
  logic                    i_start;
  logic [8*KEY_LENGTH-1:0] i_secret_key;
  logic [7:0]              i_s_q;
  logic [7:0]              o_address;
  logic [7:0]              o_data;
  logic                    o_s_wren;
  logic                    o_busy;
  logic                    o_finish;

  // master: top level / RAM side; slave: the key-scheduler itself
  modport master (
    output i_start, i_secret_key, i_s_q,
    input  o_address, o_data, o_s_wren, o_busy, o_finish
  );

  modport slave (
    input  i_start, i_secret_key, i_s_q,
    output o_address, o_data, o_s_wren, o_busy, o_finish
  );
endinterface
`default_nettype wire

// File: rtl/rc4_ksa_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : rc4_ksa_fsm
//  Purpose  : RC4 key-scheduling stage. Writes the identity permutation into
//             the 256x8 S RAM, then shuffles it with the secret key. The
//             finish pulse hands the S RAM over to the decrypt stage.
//  Ports    :
//    clk   in  single clock, all state changes on rising edge
//    rst   in  synchronous active-high reset
//    bus   slave modport of rc4_ksa_fsm_if (start, key, S RAM bus, status)
//  Revision : 1.0  initial release
// ============================================================================
module rc4_ksa_fsm #(
  parameter int KEY_LENGTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  rc4_ksa_fsm_if.slave bus
);

  localparam int KIDX_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INIT_WR   = 4'd1,
    S_SH_ADDR_I = 4'd2,
    S_SH_READ_I = 4'd3,
    S_SH_CALC_J = 4'd4,
    S_SH_ADDR_J = 4'd5,
    S_SH_READ_J = 4'd6,
    S_SH_WR_I   = 4'd7,
    S_SH_WR_J   = 4'd8,
    S_SH_NEXT   = 4'd9,
    S_DONE      = 4'd10
  } state_t;

  state_t                  r_state;
  logic [7:0]              r_i;
  logic [7:0]              r_j;
  logic [7:0]              r_si;
  logic [KIDX_W-1:0]       r_kidx;
  logic [8*KEY_LENGTH-1:0] r_key;

  logic [7:0]              r_address;
  logic [7:0]              r_data;
  logic                    r_s_wren;
  logic                    r_busy;
  logic                    r_finish;

  logic [7:0]              w_key_byte;
  logic [7:0]              w_j_next;

  // key byte k lives at the MSB end: key[0] is the top byte
  always_comb begin
    w_key_byte = '0;
    for (int b = 0; b < KEY_LENGTH; b++) begin
      if (r_kidx == KIDX_W'(b)) begin
        w_key_byte = r_key[8*(KEY_LENGTH-1-b) +: 8];
      end
    end
  end

  assign w_j_next = r_j + r_si + w_key_byte;

  // Outputs are registered: each transition loads the address/data/wren
  // that the *next* state presents. Anything not loaded defaults to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_si      <= '0;
      r_kidx    <= '0;
      r_address <= '0;
      r_data    <= '0;
      r_s_wren  <= 1'b0;
      r_busy    <= 1'b0;
      r_finish  <= 1'b0;
    end else begin
      r_address <= '0;
      r_data    <= '0;
      r_s_wren  <= 1'b0;
      r_finish  <= 1'b0;
      r_busy    <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_key    <= bus.i_secret_key;
            r_i      <= '0;
            r_j      <= '0;
            r_kidx   <= '0;
            r_s_wren <= 1'b1;   // first identity write: address=data=0
            r_state  <= S_INIT_WR;
          end else begin
            r_busy <= 1'b0;
          end
        end

        S_INIT_WR: begin
          r_i <= r_i + 8'd1;    // wraps to 0 after the last write
          if (r_i == 8'hFF) begin
            r_state <= S_SH_ADDR_I;
          end else begin
            r_address <= r_i + 8'd1;
            r_data    <= r_i + 8'd1;
            r_s_wren  <= 1'b1;
          end
        end

        S_SH_ADDR_I: begin
          r_address <= r_i;
          r_state   <= S_SH_READ_I;
        end

        S_SH_READ_I: begin
          r_si    <= bus.i_s_q;
          r_state <= S_SH_CALC_J;
        end

        S_SH_CALC_J: begin
          r_j       <= w_j_next;
          r_address <= w_j_next;
          r_state   <= S_SH_ADDR_J;
        end

        S_SH_ADDR_J: begin
          r_address <= r_j;
          r_state   <= S_SH_READ_J;
        end

        S_SH_READ_J: begin
          // S[j] goes straight into the data register; it is only ever
          // needed as the write data of the S[i] update.
          r_address <= r_i;
          r_data    <= bus.i_s_q;
          r_s_wren  <= 1'b1;
          r_state   <= S_SH_WR_I;
        end

        S_SH_WR_I: begin
          r_address <= r_j;
          r_data    <= r_si;
          r_s_wren  <= 1'b1;
          r_state   <= S_SH_WR_J;
        end

        S_SH_WR_J: begin
          r_state <= S_SH_NEXT;
        end

        S_SH_NEXT: begin
          r_kidx <= (r_kidx == KIDX_W'(KEY_LENGTH-1)) ? '0 : r_kidx + KIDX_W'(1);
          if (r_i == 8'hFF) begin
            r_finish <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_i       <= r_i + 8'd1;
            r_address <= r_i + 8'd1;
            r_state   <= S_SH_ADDR_I;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_address = r_address;
  assign bus.o_data    = r_data;
  assign bus.o_s_wren  = r_s_wren;
  assign bus.o_busy    = r_busy;
  assign bus.o_finish  = r_finish;

endmodule
`default_nettype wire

// File: tb/tb_rc4_ksa_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rc4_ksa_fsm
//  Purpose  : Self-checking bench for rc4_ksa_fsm. A 256-byte RAM model sits
//             on the S RAM bus; a software RC4 KSA predicts every write into
//             a scoreboard queue and the final S array.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rc4_ksa_fsm;
  localparam int KEY_LENGTH = 3;
  localparam int KW         = 8 * KEY_LENGTH;
  localparam int FIN_CYC    = 2305;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rc4_ksa_fsm_if #(.KEY_LENGTH(KEY_LENGTH)) bus ();
  rc4_ksa_fsm #(.KEY_LENGTH(KEY_LENGTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- RAM model: address registered, read data valid next cycle
  logic [7:0] mem [256];
  logic [7:0] ram_addr;
  initial for (int k = 0; k < 256; k++) mem[k] = 8'hA5 ^ 8'(k);
  always @(posedge clk) begin
    if (bus.o_s_wren === 1'b1) mem[bus.o_address] <= bus.o_data;
    ram_addr <= bus.o_address;
  end
  assign bus.i_s_q = mem[ram_addr];

  // ---------------- counters / scoreboard
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_q [$];     // {address, data} of every predicted write
  logic [7:0]  exp_s [256];   // predicted final S array
  logic [15:0] exp_w;
  logic [15:0] sh_wr0, sh_wr1;
  int n_wr, n_fin, fin_cyc, t0;

  always @(negedge clk) begin
    if (bus.o_s_wren === 1'b1) begin
      if (n_wr == 256) sh_wr0 = {bus.o_address, bus.o_data};
      if (n_wr == 257) sh_wr1 = {bus.o_address, bus.o_data};
      n_wr++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_write: unexpected write addr=%h data=%h, none expected",
                 bus.o_address, bus.o_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({bus.o_address, bus.o_data} !== exp_w) begin
          errors++;
          $display("FAIL sb_write: got addr=%h data=%h, expected addr=%h data=%h",
                   bus.o_address, bus.o_data, exp_w[15:8], exp_w[7:0]);
        end
      end
    end
    if (bus.o_finish === 1'b1) begin
      n_fin++;
      fin_cyc = cyc;
    end
  end

  // ---------------- software RC4 KSA, pushes the expected write stream
  task automatic push_run(input logic [KW-1:0] key);
    logic [7:0] s [256];
    logic [7:0] kb;
    int j;
    for (int k = 0; k < 256; k++) begin
      s[k] = 8'(k);
      exp_q.push_back({8'(k), 8'(k)});
    end
    j = 0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] t;
      kb = key[8*(KEY_LENGTH-1-(i % KEY_LENGTH)) +: 8];
      j  = (j + int'(s[i]) + int'(kb)) & 255;
      exp_q.push_back({8'(i), s[j]});
      exp_q.push_back({8'(j), s[i]});
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int k = 0; k < 256; k++) exp_s[k] = s[k];
  endtask

  // pulse start for one cycle; cycle 0 is the cycle in which start is sampled
  task automatic start_run(input logic [KW-1:0] key);
    @(negedge clk);
    bus.i_secret_key = key;
    bus.i_start      = 1'b1;
    t0 = cyc; n_wr = 0; n_fin = 0; fin_cyc = -1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_finish(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2400; n++) begin
      @(negedge clk);
      if (bus.o_finish === 1'b1) begin ok = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  function automatic int s_bad();
    int bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) bad++;
    return bad;
  endfunction

  // ---------------- tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_s_wren, bus.o_busy, bus.o_finish, bus.o_address, bus.o_data} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: wren=%b busy=%b finish=%b addr=%h data=%h, expected all 0",
               bus.o_s_wren, bus.o_busy, bus.o_finish, bus.o_address, bus.o_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.o_s_wren, bus.o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_start: wren=%b busy=%b, expected 0 0", bus.o_s_wren, bus.o_busy);
    end
  endtask

  task automatic test_init_fill();
    int bad = 0, first = -1;
    bit ok;
    push_run('0);
    start_run('0);
    for (int k = 0; k < 256; k++) begin   // now in cycle 1+k
      if ({bus.o_s_wren, bus.o_busy, bus.o_address, bus.o_data} !== {2'b11, 8'(k), 8'(k)}) begin
        bad++;
        if (first < 0) first = k;
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_fill: %0d bad cycles (first k=%0d), expected wren=busy=1 addr=data=k", bad, first);
    end
    wait_finish(ok);
    checks++;
    if (!ok || s_bad() != 0) begin
      errors++;
      $display("FAIL init_key0_result: finished=%0b bad_bytes=%0d, expected 1 and 0", ok, s_bad());
    end
  endtask

  task automatic test_first_shuffle();
    bit ok;
    push_run(24'hFF0000);
    start_run(24'hFF0000);
    wait_finish(ok);
    checks++;
    if (sh_wr0 !== 16'h00FF || sh_wr1 !== 16'hFF00) begin
      errors++;
      $display("FAIL first_shuffle: got %h then %h, expected 00FF then FF00", sh_wr0, sh_wr1);
    end
    checks++;
    if (!ok || s_bad() != 0) begin
      errors++;
      $display("FAIL key_ff0000_result: finished=%0b bad_bytes=%0d, expected 1 and 0", ok, s_bad());
    end
  endtask

  task automatic test_full_run();
    bit ok;
    push_run(24'h000249);
    start_run(24'h000249);
    wait_finish(ok);
    checks++;
    if (!ok || fin_cyc !== t0 + FIN_CYC) begin
      errors++;
      $display("FAIL finish_latency: finished=%0b at cycle %0d, expected cycle %0d",
               ok, fin_cyc - t0, FIN_CYC);
    end
    checks++;
    if (n_fin !== 1) begin
      errors++;
      $display("FAIL finish_count: %0d pulses, expected 1", n_fin);
    end
    checks++;
    if (n_wr !== 768) begin
      errors++;
      $display("FAIL write_count: %0d writes, expected 768", n_wr);
    end
    checks++;
    if (s_bad() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL key_000249_result: bad_bytes=%0d leftover=%0d, expected 0 0", s_bad(), exp_q.size());
    end
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done: busy=%b, expected 0", bus.o_busy);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    push_run(24'h13579B);
    start_run(24'h13579B);
    while (cyc < t0 + 1000) @(negedge clk);
    rst = 1'b1;                       // sampled at the end of cycle 1000
    @(negedge clk);
    checks++;
    if ({bus.o_s_wren, bus.o_busy, bus.o_finish} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset: wren=%b busy=%b finish=%b, expected 0 0 0",
               bus.o_s_wren, bus.o_busy, bus.o_finish);
    end
    rst = 1'b0;
    exp_q.delete();
    push_run(24'h13579B);
    start_run(24'h13579B);
    wait_finish(ok);
    checks++;
    if (!ok || fin_cyc !== t0 + FIN_CYC || s_bad() != 0) begin
      errors++;
      $display("FAIL after_reset_run: finished=%0b cycle=%0d bad_bytes=%0d, expected 1 %0d 0",
               ok, fin_cyc - t0, s_bad(), FIN_CYC);
    end
  endtask

  task automatic test_start_ignored();
    push_run(24'h1A2B3C);
    start_run(24'h1A2B3C);
    while (cyc - t0 < FIN_CYC + 4) begin
      bus.i_start = (cyc - t0 == 10) || (cyc - t0 == 300) ||
                    (cyc - t0 == 1500) || (cyc - t0 == FIN_CYC);
      if (cyc - t0 == 20) bus.i_secret_key = 24'hC0FFEE;
      if (cyc - t0 == FIN_CYC + 2) begin
        checks++;
        if ({bus.o_busy, bus.o_s_wren} !== 2'b00) begin
          errors++;
          $display("FAIL start_in_done_ignored: busy=%b wren=%b, expected 0 0", bus.o_busy, bus.o_s_wren);
        end
      end
      @(negedge clk);
    end
    bus.i_start = 1'b0;
    checks++;
    if (n_fin !== 1 || fin_cyc !== t0 + FIN_CYC || n_wr !== 768) begin
      errors++;
      $display("FAIL no_restart: finishes=%0d at %0d writes=%0d, expected 1 at %0d writes=768",
               n_fin, fin_cyc - t0, n_wr, FIN_CYC);
    end
    checks++;
    if (s_bad() != 0) begin
      errors++;
      $display("FAIL key_change_ignored: bad_bytes=%0d, expected 0", s_bad());
    end
  endtask

  task automatic test_back_to_back();
    push_run(24'h0A0B0C);
    push_run(24'h445566);             // second run latches the key present at its start
    @(negedge clk);
    bus.i_secret_key = 24'h0A0B0C;
    bus.i_start      = 1'b1;
    t0 = cyc; n_wr = 0; n_fin = 0; fin_cyc = -1;
    while (cyc - t0 < 2 * (FIN_CYC + 1) + 2) begin
      if (cyc - t0 == 100) bus.i_secret_key = 24'h445566;
      if (cyc - t0 == FIN_CYC + 2) bus.i_start = 1'b0;
      if (cyc - t0 == FIN_CYC + 1) begin
        checks++;
        if (bus.o_busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle_gap: busy=%b in cycle %0d, expected 0", bus.o_busy, FIN_CYC + 1);
        end
      end
      if (cyc - t0 == FIN_CYC + 2) begin
        checks++;
        if ({bus.o_busy, bus.o_s_wren, bus.o_address} !== {2'b11, 8'h00}) begin
          errors++;
          $display("FAIL b2b_restart: busy=%b wren=%b addr=%h, expected 1 1 00",
                   bus.o_busy, bus.o_s_wren, bus.o_address);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (n_fin !== 2 || fin_cyc !== t0 + 2*FIN_CYC + 1 || n_wr !== 1536) begin
      errors++;
      $display("FAIL b2b_second_run: finishes=%0d last=%0d writes=%0d, expected 2 %0d 1536",
               n_fin, fin_cyc - t0, n_wr, 2*FIN_CYC + 1);
    end
    checks++;
    if (s_bad() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_result: bad_bytes=%0d leftover=%0d, expected 0 0", s_bad(), exp_q.size());
    end
  endtask

  initial begin
    bus.i_start      = 1'b0;
    bus.i_secret_key = '0;
    n_wr = 0; n_fin = 0; fin_cyc = -1; t0 = 0;
    sh_wr0 = '0; sh_wr1 = '0;
    test_reset();
    test_init_fill();
    test_first_shuffle();
    test_full_run();
    test_mid_reset();
    test_start_ignored();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
